// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer and its rate prescaler.
// Imported by counter_seq and counter_seq_div.

package counter_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDST = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    function automatic logic is_busy(input state_e st);
        return st != S_IDLE;
    endfunction

endpackage

// File: rtl/counter_seq_div.sv
// Rate prescaler: counts enabled cycles and raises tick when the count equals div_i.
// The count self-clears on the ticking cycle so a tick recurs every div_i+1 enabled cycles.

module counter_seq_div
    import counter_seq_pkg::*;
#(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_seq.sv
// Sequencer for a loadable up-counter: loads a start value, increments at a divided rate
// until the terminal count, pulses done, then idles (one-shot) or reloads (periodic).

module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] start_val_i,
    input  logic [WIDTH-1:0] end_val_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             load_o,
    output logic [WIDTH-1:0] data_o,
    output logic             inc_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;

    logic tick;
    logic at_end;
    logic presc_clr;
    logic presc_en;

    assign at_end    = (count_i == end_q);
    assign presc_clr = (state_q != S_RUN);
    assign presc_en  = (state_q == S_RUN);

    counter_seq_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (presc_clr),
        .en_i   (presc_en),
        .div_i  (div_q),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        mode_d  = mode_q;
        div_d   = div_q;
        done_d  = 1'b0;
        load_o  = 1'b0;
        inc_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    start_d = start_val_i;
                    end_d   = end_val_i;
                    mode_d  = mode_i;
                    div_d   = div_i;
                    state_d = S_LDST;
                end
            end
            S_LDST: begin
                load_o = 1'b1;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Stop suppresses the final INC so the counter holds where it was aborted.
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    done_d  = 1'b1;
                    state_d = (mode_q == MODE_PERIODIC) ? S_LDST : S_IDLE;
                end else begin
                    inc_o = tick;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_o = start_q;
    assign busy_o = is_busy(state_q);
    assign done_o = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            start_q <= '0;
            end_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq driving a behavioural loadable up-counter.
// Cycle 0 is the cycle in which start_i is first seen high; samples are taken #1 after each edge.

module tb_counter_seq;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DIV_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             inc;
    logic             busy;
    logic             done;

    int n_checks;
    int n_pass;

    counter_seq #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .mode_i      (mode),
        .start_val_i (start_val),
        .end_val_i   (end_val),
        .div_i       (div),
        .count_i     (count),
        .load_o      (load),
        .data_o      (data),
        .inc_o       (inc),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Loadable up-counter: LOAD beats INC, wraps modulo 2^WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= data;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called during cycle 0: presents config with start high, returns during cycle 1.
    task automatic start_run(input int sv, input int ev, input logic md, input int dv);
        start_val = sv[WIDTH-1:0];
        end_val   = ev[WIDTH-1:0];
        mode      = md;
        div       = dv[DIV_W-1:0];
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Observes cycles 1..last (bounded); ends during cycle last.
    task automatic watch(input int last, output int first_done, output int n_done,
                         output int n_inc);
        first_done = -1;
        n_done     = 0;
        n_inc      = 0;
        for (int c = 1; c <= last; c++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (inc) n_inc++;
            if (c < last) step();
        end
    endtask

    int first_done;
    int n_done;
    int n_inc;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 1'b0;
        start_val = '0;
        end_val   = '0;
        div       = '0;
        #23;
        check("rst_busy", busy, 0);
        check("rst_load", load, 0);
        check("rst_inc", inc, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        check("rst_count", count, 0);
        rst = 1'b0;
        step();

        // One-shot 2 -> 5, DIV=0
        start_run(2, 5, 1'b0, 0);
        check("os_load_c1", load, 1);
        check("os_data_c1", data, 2);
        check("os_busy_c1", busy, 1);
        check("os_inc_c1", inc, 0);
        for (int c = 2; c <= 5; c++) begin
            step();
            check($sformatf("os_count_c%0d", c), count, c);
            check($sformatf("os_inc_c%0d", c), inc, (c != 5) ? 1 : 0);
            check($sformatf("os_done_c%0d", c), done, 0);
        end
        step();
        check("os_done_c6", done, 1);
        check("os_busy_c6", busy, 0);
        check("os_load_c6", load, 0);
        step();
        check("os_done_c7", done, 0);
        check("os_inc_c7", inc, 0);
        check("os_count_c7", count, 5);
        step();

        // Divided rate 0 -> 3, DIV=2
        start_run(0, 3, 1'b0, 2);
        watch(14, first_done, n_done, n_inc);
        check("div_done_cycle", first_done, 12);
        check("div_done_count", n_done, 1);
        check("div_inc_pulses", n_inc, 3);
        check("div_final_count", count, 3);
        check("div_busy_end", busy, 0);
        step();

        // Periodic wrap 14 -> 1, DIV=0
        start_run(14, 1, 1'b1, 0);
        for (int c = 1; c <= 17; c++) begin
            automatic bit exp_done = (c == 6) || (c == 11) || (c == 16);
            check($sformatf("per_done_c%0d", c), done, exp_done ? 1 : 0);
            if (exp_done) check($sformatf("per_load_c%0d", c), load, 1);
            if (c == 2) check("per_count_c2", count, 14);
            if (c == 3) check("per_count_c3", count, 15);
            if (c == 4) check("per_count_c4", count, 0);
            if (c == 5) check("per_count_c5", count, 1);
            if (c < 17) step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("per_stop_busy", busy, 0);
        step();

        // Stop mid-run at COUNT=4 in a 2 -> 9 run
        start_run(2, 9, 1'b0, 0);
        step();
        step();
        step();
        check("stop_count_c4", count, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_inc", inc, 0);
        check("stop_load", load, 0);
        check("stop_count", count, 4);
        watch(8, first_done, n_done, n_inc);
        check("stop_no_done", n_done, 0);
        check("stop_count_hold", count, 4);

        // Start and stop together in idle
        start_val = 4'd7;
        start     = 1'b1;
        stop      = 1'b1;
        n_done    = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (load || busy) n_done++;
        end
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_idle", n_done, 0);
        step();

        // Start while busy is ignored
        start_run(0, 3, 1'b0, 0);
        step();
        start_val = 4'd9;
        end_val   = 4'd10;
        start     = 1'b1;
        step();
        start = 1'b0;
        watch(5, first_done, n_done, n_inc);
        check("busy_start_done_cycle", first_done + 2, 6);
        check("busy_start_count", count, 3);
        check("busy_start_data", data, 0);
        step();
        check("busy_start_idle", busy, 0);
        step();

        // Async reset mid-run
        start_run(2, 9, 1'b0, 0);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_load", load, 0);
        check("arst_inc", inc, 0);
        check("arst_done", done, 0);
        check("arst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        start_run(0, 2, 1'b0, 0);
        watch(7, first_done, n_done, n_inc);
        check("arst_rerun_done", first_done, 5);
        check("arst_rerun_count", count, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/counter_seq.md
Name: counter_seq

Overview:
- Sequencer for the team's loadable up-counter (COUNTER: CLK, RESET, LOAD, DATA, INC, COUNT).
- Drives the counter's LOAD/DATA/INC and reads back COUNT.
- Runs the counter from a programmed start value to a programmed end value, at a programmable increment rate, in one-shot or periodic (auto-reload) mode.
- Signals each terminal count with a DONE pulse.
- Sits between a host/control register block and one COUNTER instance. Both share CLK and RESET.

Parameters:
- WIDTH, 4, counter width; must match the attached COUNTER.
- DIV_W, 4, width of the rate divider field.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  start request; sampled only in IDLE.
- STOP  in  1  abort; honoured in any state.
- MODE  in  1  0 = one-shot, 1 = periodic.
- START_VAL  in  WIDTH  value loaded at each run start.
- END_VAL  in  WIDTH  terminal count.
- DIV  in  DIV_W  INC issued once every DIV+1 RUN cycles.
- COUNT  in  WIDTH  counter output; registered in COUNTER.
- LOAD  out  1  to COUNTER.LOAD.
- DATA  out  WIDTH  to COUNTER.DATA.
- INC  out  1  to COUNTER.INC.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle terminal-count pulse.

Behaviour:
- Counter contract: LOAD has priority over INC. COUNT updates on the edge after LOAD/INC. COUNT wraps modulo 2^WIDTH.
- Reset (async, immediate):
  - state = IDLE.
  - LOAD = INC = BUSY = DONE = 0.
  - DATA = 0; latched start/end/mode/div = 0; prescaler = 0.
  - Deassertion is synchronised by the normal flop path; no extra requirement.
- States: IDLE, LDST, RUN.
- IDLE:
  - START=1 and STOP=0: latch START_VAL, END_VAL, MODE, DIV into internal regs; next = LDST.
  - START and STOP together: STOP wins; stay IDLE.
- LDST:
  - LOAD = 1, DATA = latched start, INC = 0.
  - Next = RUN; prescaler cleared to 0.
- RUN:
  - Prescaler increments each cycle.
  - INC = 1 exactly when prescaler == latched DIV and COUNT != latched END; prescaler returns to 0 that cycle.
  - INC is combinational from state, prescaler and COUNT; there is no loop because COUNT is registered.
  - COUNT == latched END: INC = 0, DONE registered high for the following cycle.
    - One-shot: next = IDLE; DONE coincides with the first IDLE cycle, BUSY = 0.
    - Periodic: next = LDST; DONE coincides with the reload LOAD cycle.
- Distance N = (END - START) mod 2^WIDTH. END < START counts through 2^WIDTH-1 -> 0.
- START == END: DONE with N = 0; RUN lasts 1 cycle.
- Latency, START sampled at cycle 0:
  - LOAD at cycle 1.
  - RUN spans N*(DIV+1)+1 cycles.
  - DONE at cycle 3 + N*(DIV+1).
  - Periodic DONE period = N*(DIV+1) + 2 cycles.
- STOP in LDST or RUN:
  - Next = IDLE; no DONE; LOAD/INC = 0 from the next cycle.
  - COUNT is left at its current value.
  - STOP in the same cycle as terminal detection: STOP wins, no DONE.
- START while BUSY: ignored; latched config unchanged. Input changes during a run have no effect until the next start.
- DATA holds the latched start value when not in LDST (stable bus).
- RESET mid-run: immediate IDLE; the counter is reset by the same RESET.

Decomposition:
- Shared package/define file counter_seq_pkg:
  - State encodings S_IDLE = 2'd0, S_LDST = 2'd1, S_RUN = 2'd2.
  - MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- Sub-module counter_seq_div: rate prescaler.
  - Inputs: CLK, RESET, CLR, EN, DIV.
  - Output: TICK, high when the count equals DIV.
  - Self-clears on TICK.
- Bench instantiates counter_seq + COUNTER together.

Test Plan:
- One-shot, WIDTH=4, START_VAL=2, END_VAL=5, DIV=0, pulse START at cycle 0 -> LOAD at cycle 1; COUNT 2,3,4,5 on cycles 2..5; DONE=1 only at cycle 6; BUSY low from cycle 6; no further INC.
- Divided rate, START_VAL=0, END_VAL=3, DIV=2 -> INC every 3rd RUN cycle; DONE at cycle 12; exactly 3 INC pulses total.
- Wrap, START_VAL=14, END_VAL=1, DIV=0, periodic -> COUNT 14,15,0,1; DONE every 5 cycles (cycles 6,11,16); LOAD coincident with each DONE.
- STOP mid-run at COUNT=4 (2->9 run) -> IDLE next cycle, no DONE, COUNT holds 4. START with STOP both high in IDLE -> stays IDLE, LOAD never asserts.
- START while BUSY with a different START_VAL -> ignored; original run completes with the original DONE timing.
- Async RESET asserted mid-RUN between clock edges -> BUSY, LOAD, INC, DONE = 0 immediately; COUNT = 0. A START after release runs normally.
